vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Parameters
REQ-001 The block SHALL have parameter H_DISPLAY, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, meaning horizontal front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, meaning horizontal back-porch pixels.
REQ-005 The block SHALL have parameter V_DISPLAY, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 10, meaning vertical front-porch lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse lines.
REQ-008 The block SHALL have parameter V_BACK, default 33, meaning vertical back-porch lines.

Interface
REQ-009 clk  input  1  100 MHz system clock; all state changes on its rising edge.
REQ-010 reset_n  input  1  asynchronous, active-low reset.
REQ-011 hsync  output  1  horizontal sync, active low.
REQ-012 vsync  output  1  vertical sync, active low.
REQ-013 video_on  output  1  high while (pixel_x, pixel_y) lies in the visible area.
REQ-014 p_tick  output  1  one-clk pixel-enable pulse, one every 4 clk (25 MHz).
REQ-015 pixel_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-016 pixel_y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-017 frame_start  output  1  one-clk pulse when counters wrap to (0,0).

Function
REQ-018 H_TOTAL SHALL be H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL be V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 A 2-bit divider SHALL increment every clk, wrapping 3->0; p_tick SHALL be high exactly while divider==3.
REQ-020 h_count SHALL advance only on a clk edge where p_tick=1, incrementing by 1, and wrap H_TOTAL-1 -> 0.
REQ-021 v_count SHALL advance only on the edge where h_count wraps, incrementing by 1, and wrap V_TOTAL-1 -> 0.
REQ-022 pixel_x and pixel_y SHALL be the h_count and v_count registers directly (zero latency vs. counters).
REQ-023 hsync SHALL be registered and low exactly while h_count is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), changing on the same edge as h_count.
REQ-024 vsync SHALL be registered and low exactly while v_count is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), changing on the same edge as v_count.
REQ-025 video_on SHALL be high exactly when h_count<H_DISPLAY and v_count<V_DISPLAY, aligned with pixel_x/pixel_y.
REQ-026 frame_start SHALL be high for the single clk following the edge where both counters wrap to 0.
REQ-027 Simultaneous h and v wrap (h=799, v=524, p_tick=1) SHALL yield h=0, v=0, frame_start=1 on the same edge.
REQ-028 Between p_tick edges all outputs except p_tick SHALL hold their values.

Reset
REQ-029 reset_n low SHALL immediately, without waiting for clk, force divider=0, h_count=0, v_count=0, hsync=1, vsync=1, video_on=1, p_tick=0, frame_start=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release counting SHALL restart from (0,0), first p_tick on the 4th rising clk edge after release.

Verification
REQ-031 Release reset, 8 clk -> p_tick high on clk cycles 3 and 7 only; pixel_x goes 0->1 on cycle 3 edge, 1->2 on cycle 7 edge.
REQ-032 Run one line (3200 clk) -> hsync low for exactly 96 p_ticks starting at pixel_x=656; video_on falls when pixel_x becomes 640; pixel_y increments when pixel_x wraps 799->0.
REQ-033 Run one full frame (1,680,000 clk) -> vsync low for exactly 2 lines (pixel_y 490, 491); video_on low for all pixel_y>=480; frame_start pulses once, coincident with wrap to (0,0).
REQ-034 Assert reset_n low at pixel_x=700, pixel_y=300, between clk edges -> outputs take reset values before next clk edge; after release, sequence matches REQ-031.
REQ-035 Override parameters to H 8/2/2/2, V 4/1/1/1 -> hsync low at pixel_x 10..11, vsync low at pixel_y 5, H_TOTAL 14, V_TOTAL 7 wrap correctly.

Source files
------------

// File: rtl/vga_sync.sv
// VGA timing generator: divides clk by 4 into a pixel tick, runs the
// horizontal/vertical counters on that tick, and produces registered
// active-low sync pulses, a visible-area flag and a frame-start strobe.
module vga_sync #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // All timing boundaries as 10-bit constants so compares stay width-matched.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [1:0] r_div;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_frame_start;

  logic       w_tick;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;

  assign w_tick   = (r_div == 2'd3);
  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  // Next counter values; syncs are decoded from these so they land on the
  // same edge as the counters they describe.
  always_comb begin
    w_h_nxt = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
    w_v_nxt = r_v_cnt;
    if (w_h_wrap) w_v_nxt = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
  end

  // Free-running clk/4 divider; its terminal count is the pixel tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_div <= 2'd0;
    else          r_div <= r_div + 2'd1;
  end

  // Pixel counters and registered sync pulses, advanced only on the tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_tick) begin
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_hsync <= !((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
      r_vsync <= !((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
    end
  end

  // One-clk strobe after the edge that wraps both counters back to (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_frame_start <= 1'b0;
    else          r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
  end

  assign p_tick      = w_tick;
  assign pixel_x     = r_h_cnt;
  assign pixel_y     = r_v_cnt;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;
  assign video_on    = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: a default-timing instance and a tiny-timing
// instance share clock and reset. Each cycle the stimulus pushes the expected
// outputs of both, derived from the number of clk edges since reset release;
// a negedge monitor pops and compares.
module tb_vga_sync;

  typedef struct packed {
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       frame_start;
    logic [9:0] px;
    logic [9:0] py;
  } obs_t;

  typedef struct {
    obs_t d;
    obs_t s;
  } pair_t;

  logic       clk;
  logic       reset_n;
  obs_t       got_d, got_s;

  pair_t      sb[$];
  longint     n;
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_sync u_dflt (
    .clk        (clk),
    .reset_n    (reset_n),
    .hsync      (got_d.hsync),
    .vsync      (got_d.vsync),
    .video_on   (got_d.video_on),
    .p_tick     (got_d.p_tick),
    .pixel_x    (got_d.px),
    .pixel_y    (got_d.py),
    .frame_start(got_d.frame_start)
  );

  vga_sync #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .clk        (clk),
    .reset_n    (reset_n),
    .hsync      (got_s.hsync),
    .vsync      (got_s.vsync),
    .video_on   (got_s.video_on),
    .p_tick     (got_s.p_tick),
    .pixel_x    (got_s.px),
    .pixel_y    (got_s.py),
    .frame_start(got_s.frame_start)
  );

  // Reference: k = clk edges since reset release. Pixel ticks so far = k/4;
  // position is that tick count folded into the line/frame raster.
  function automatic obs_t model(input longint k, input int hd, input int hf,
                                 input int hs, input int hb, input int vd,
                                 input int vf, input int vs, input int vb);
    obs_t   o;
    longint ht, vt, ticks, h, v;
    ht    = hd + hf + hs + hb;
    vt    = vd + vf + vs + vb;
    ticks = k / 4;
    h     = ticks % ht;
    v     = (ticks / ht) % vt;
    o.p_tick      = (k % 4 == 3);
    o.px          = 10'(h);
    o.py          = 10'(v);
    o.hsync       = !(h >= hd + hf && h < hd + hf + hs);
    o.vsync       = !(v >= vd + vf && v < vd + vf + vs);
    o.video_on    = (h < hd) && (v < vd);
    o.frame_start = (k > 0) && (k % 4 == 0) && (ticks % (ht * vt) == 0);
    return o;
  endfunction

  function automatic pair_t expect_at(input longint k);
    pair_t p;
    p.d = model(k, 640, 16, 96, 48, 480, 10, 2, 33);
    p.s = model(k, 8, 2, 2, 2, 4, 1, 1, 1);
    return p;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got pt=%b hs=%b vs=%b von=%b fs=%b x=%0d y=%0d required pt=%b hs=%b vs=%b von=%b fs=%b x=%0d y=%0d",
               name, $time, got.p_tick, got.hsync, got.vsync, got.video_on,
               got.frame_start, got.px, got.py, exp.p_tick, exp.hsync,
               exp.vsync, exp.video_on, exp.frame_start, exp.px, exp.py);
    end
  endtask

  // Monitor: outputs are presented every cycle, sampled mid-cycle.
  always @(negedge clk) begin
    pair_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare("dflt", got_d, e.d);
      compare("small", got_s, e.s);
    end
  end

  // One clk: count the edge if reset was released, then (between edges)
  // optionally assert reset and queue the expected outputs for this cycle.
  task automatic cyc(input bit rst);
    @(posedge clk);
    if (reset_n) n++;
    #1;
    if (rst) begin
      reset_n = 1'b0;
      n       = 0;
    end else begin
      reset_n = 1'b1;
    end
    sb.push_back(expect_at(n));
  endtask

  task automatic run(input int cycles);
    repeat (cycles) cyc(1'b0);
  endtask

  task automatic hold_reset(input int cycles);
    repeat (cycles) cyc(1'b1);
  endtask

  initial begin
    int target;
    reset_n = 1'b0;
    n       = 0;

    hold_reset(3);
    run(8);                       // first two pixel ticks after release
    run(3400);                    // a full default line plus margin

    hold_reset(2);
    target = 2800 + int'($urandom_range(0, 3));
    while (n < target) cyc(1'b0); // default instance near pixel_x=700
    hold_reset(int'($urandom_range(1, 4)));
    run(8);

    for (int i = 0; i < 5; i++) begin
      run(int'($urandom_range(100, 2500)));
      hold_reset(int'($urandom_range(1, 3)));
    end
    run(1200);                    // several complete tiny frames

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
